// File: rtl/divmod_seq.sv
// Iterative radix-2 restoring divider with truncated/floored sign correction.
// One quotient bit per clock, start/busy/done handshake, runtime modulus.
module divmod_seq #(
  parameter int WIDTH     = 16,
  parameter int MOD_WIDTH = 8,
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [MOD_WIDTH-1:0] divisor,
  input  logic                 floor_mode,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [MOD_WIDTH:0]   remainder,
  output logic                 div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   neg_q, neg_d;
  logic                   floor_q, floor_d;
  logic [MOD_WIDTH-1:0]   div_q, div_d;
  logic [MOD_WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]       quo_q, quo_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       quotient_q, quotient_d;
  logic [MOD_WIDTH:0]     remainder_q, remainder_d;
  logic                   dbz_q, dbz_d;

  logic                   in_neg;
  logic [WIDTH-1:0]       in_abs;
  logic [MOD_WIDTH:0]     rem_shift;
  logic                   rem_fits;

  assign in_neg    = SIGNED_IN && dividend[WIDTH-1];
  // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign in_abs    = in_neg ? (-dividend) : dividend;
  assign rem_shift = {rem_q[MOD_WIDTH-1:0], quo_q[WIDTH-1]};
  assign rem_fits  = (rem_shift >= {1'b0, div_q});

  // Next-state and datapath logic for the divide sequencer.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    neg_d       = neg_q;
    floor_d     = floor_q;
    div_d       = div_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        done_d = 1'b0;
        if (start) begin
          state_d = S_CALC;
          busy_d  = 1'b1;
          neg_d   = in_neg;
          floor_d = floor_mode;
          div_d   = divisor;
          quo_d   = in_abs;
          rem_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (rem_fits) begin
          rem_d = rem_shift - {1'b0, div_q};
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = 1'b0;
        if (div_q == '0) begin
          quotient_d  = '1;
          remainder_d = '0;
          dbz_d       = 1'b1;
        end else if (!neg_q) begin
          quotient_d  = quo_q;
          remainder_d = rem_q;
        end else if (!floor_q) begin
          quotient_d  = -quo_q;
          remainder_d = -rem_q;
        end else if (rem_q != '0) begin
          // -(q0+1) is the bitwise complement of q0.
          quotient_d  = ~quo_q;
          remainder_d = {1'b0, div_q} - rem_q;
        end else begin
          quotient_d  = -quo_q;
          remainder_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any divide in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      neg_q       <= 1'b0;
      floor_q     <= 1'b0;
      div_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      neg_q       <= neg_d;
      floor_q     <= floor_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divmod_seq.sv
// Directed self-checking bench for divmod_seq (WIDTH=16, MOD_WIDTH=8, signed).
module tb_divmod_seq;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic [15:0]       dividend;
  logic [7:0]        divisor;
  logic              floor_mode;
  logic              busy;
  logic              done;
  logic [15:0]       quotient;
  logic [8:0]        remainder;
  logic              div_by_zero;

  int n_checks;
  int n_fails;

  divmod_seq #(.WIDTH(16), .MOD_WIDTH(8), .SIGNED_IN(1'b1)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .floor_mode  (floor_mode),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one divide and wait for done; lat = cycles from accept edge to done (0 on timeout).
  task automatic run_op(input logic [15:0] a, input logic [7:0] d, input logic fm,
                        output int lat, output logic busy_all);
    @(negedge clock);
    dividend = a; divisor = d; floor_mode = fm; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    busy_all = busy;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_all = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; dividend = 16'd0; divisor = 8'd0; floor_mode = 1'b0;
    #23;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 28'd0) begin
      n_fails++;
      $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dbz=%b, want all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic ba;
    run_op(16'd300, 8'd100, 1'b1, lat, ba);
    n_checks++;
    if (lat !== 17) begin n_fails++; $display("FAIL basic_latency: got %0d edges, want 17", lat); end
    n_checks++;
    if (ba !== 1'b1) begin n_fails++; $display("FAIL basic_busy: got busy dropout=%b, want 1", ba); end
    n_checks++;
    if (quotient !== 16'd3 || remainder !== 9'd0 || div_by_zero !== 1'b0) begin
      n_fails++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, want q=3 r=0 dbz=0", quotient, remainder, div_by_zero);
    end
    @(negedge clock);
    n_checks++;
    if (done !== 1'b0 || quotient !== 16'd3) begin
      n_fails++;
      $display("FAIL done_pulse: got done=%b q=%0d one cycle later, want done=0 q=3", done, quotient);
    end
  endtask

  task automatic test_signs();
    int lat; logic ba;
    logic [15:0] a_tab [6]  = '{16'hFF06, 16'hFF06, 16'hFF38, 16'h8000, 16'h7FFF, 16'hFB2E};
    logic [7:0]  d_tab [6]  = '{8'd100, 8'd100, 8'd100, 8'd1, 8'd255, 8'd10};
    logic        f_tab [6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] q_tab [6]  = '{16'hFFFD, 16'hFFFE, 16'hFFFE, 16'h8000, 16'd128, 16'hFF84};
    logic [8:0]  r_tab [6]  = '{9'd50, 9'h1CE, 9'd0, 9'd0, 9'd127, 9'd6};
    for (int i = 0; i < 6; i++) begin
      run_op(a_tab[i], d_tab[i], f_tab[i], lat, ba);
      n_checks++;
      if (lat !== 17 || quotient !== q_tab[i] || remainder !== r_tab[i] || div_by_zero !== 1'b0) begin
        n_fails++;
        $display("FAIL sign_case%0d: got lat=%0d q=%h r=%h dbz=%b, want lat=17 q=%h r=%h dbz=0",
                 i, lat, quotient, remainder, div_by_zero, q_tab[i], r_tab[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat; logic ba;
    run_op(16'd17, 8'd0, 1'b0, lat, ba);
    n_checks++;
    if (lat !== 17 || quotient !== 16'hFFFF || remainder !== 9'd0 || div_by_zero !== 1'b1) begin
      n_fails++;
      $display("FAIL div_zero: got lat=%0d q=%h r=%h dbz=%b, want lat=17 q=ffff r=0 dbz=1",
               lat, quotient, remainder, div_by_zero);
    end
    run_op(16'd100, 8'd7, 1'b0, lat, ba);
    n_checks++;
    if (quotient !== 16'd14 || remainder !== 9'd2 || div_by_zero !== 1'b0) begin
      n_fails++;
      $display("FAIL div_zero_clear: got q=%0d r=%0d dbz=%b, want q=14 r=2 dbz=0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    @(negedge clock);
    dividend = 16'd1000; divisor = 8'd9; floor_mode = 1'b0; start = 1'b1;
    gap = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); @(negedge clock);
      if (done) begin gap = n; break; end
    end
    n_checks++;
    if (gap !== 18 || quotient !== 16'd111 || remainder !== 9'd1) begin
      n_fails++;
      $display("FAIL b2b_first: got gap=%0d q=%0d r=%0d, want gap=18 q=111 r=1", gap, quotient, remainder);
    end
    dividend = 16'hFFF9; divisor = 8'd3; floor_mode = 1'b1;
    gap = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); @(negedge clock);
      if (done) begin gap = n; break; end
    end
    start = 1'b0;
    n_checks++;
    if (gap !== 18 || quotient !== 16'hFFFD || remainder !== 9'd2) begin
      n_fails++;
      $display("FAIL b2b_second: got gap=%0d q=%h r=%h, want gap=18 q=fffd r=002", gap, quotient, remainder);
    end
  endtask

  task automatic test_start_while_busy();
    int lat; logic extra;
    @(negedge clock);
    dividend = 16'd500; divisor = 8'd13; floor_mode = 1'b0; start = 1'b1;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); @(negedge clock);
      if (done) begin lat = n; break; end
      if (n == 3 || n == 8) begin
        start = 1'b1; dividend = 16'hFFFF; divisor = 8'd2; floor_mode = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    n_checks++;
    if (lat !== 17 || quotient !== 16'd38 || remainder !== 9'd6) begin
      n_fails++;
      $display("FAIL busy_ignore: got lat=%0d q=%0d r=%0d, want lat=17 q=38 r=6", lat, quotient, remainder);
    end
    extra = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (done || busy) extra = 1'b1;
    end
    n_checks++;
    if (extra !== 1'b0) begin
      n_fails++;
      $display("FAIL busy_no_queue: got extra activity=%b, want 0", extra);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic ba; logic seen;
    @(negedge clock);
    dividend = 16'd1234; divisor = 8'd10; floor_mode = 1'b0; start = 1'b1;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    for (int n = 1; n <= 5; n++) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 28'd0) begin
      n_fails++;
      $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h dbz=%b, want all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clock);
      if (done || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_abort: got activity after reset=%b, want 0", seen);
    end
    run_op(16'd1234, 8'd10, 1'b0, lat, ba);
    n_checks++;
    if (lat !== 17 || quotient !== 16'd123 || remainder !== 9'd4) begin
      n_fails++;
      $display("FAIL reset_recover: got lat=%0d q=%0d r=%0d, want lat=17 q=123 r=4", lat, quotient, remainder);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
